// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit frame engine.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// last cycle of each bit period (bit_end) and the cycle before it (pre_end).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_end,
    output logic pre_end
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // pre_end lets the frame engine register a flag that lands on the final cycle
    assign bit_end = run && (count == LAST);
    assign pre_end = run && (count == PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, LSB-first data, optional parity and
// one or two stop bits, sequenced by a small FSM paced by uart_bit_timer.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    tx_state_t             state, next_state;
    logic [IW-1:0]         bit_idx, next_idx;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  parity_q, par_en_q, stop2_q;
    logic                  tx_next, done_next;
    logic                  bit_end, pre_end;
    logic                  accept;
    logic [IW-1:0]         stop_last;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state != IDLE),
        .bit_end(bit_end),
        .pre_end(pre_end)
    );

    assign tx_ready  = (state == IDLE);
    assign accept    = tx_valid && tx_ready;
    assign stop_last = stop2_q ? IW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_idx  <= '0;
            tx       <= TX_IDLE_LEVEL;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            state   <= next_state;
            bit_idx <= next_idx;
            tx      <= tx_next;
            busy    <= (next_state != IDLE);
            done    <= done_next;
            if (accept) begin
                data_q   <= tx_data;
                parity_q <= (^tx_data) ^ (parity_mode == PAR_ODD);
                par_en_q <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                stop2_q  <= stop2;
            end
        end
    end

    // bit_idx doubles as the stop-bit counter once the data bits are out
    always_comb begin
        next_state = state;
        next_idx   = bit_idx;
        tx_next    = TX_IDLE_LEVEL;
        shifted    = '0;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    next_state = START;
                    next_idx   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    next_state = DATA;
                    next_idx   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        next_state = par_en_q ? PARITY : STOP;
                        next_idx   = '0;
                    end else begin
                        next_idx = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    next_state = STOP;
                    next_idx   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == stop_last) begin
                        next_state = IDLE;
                        next_idx   = '0;
                    end else begin
                        next_idx = bit_idx + 1'b1;
                    end
                end
                done_next = (bit_idx == stop_last) && pre_end;
            end
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase

        // tx is registered, so it is derived from where the FSM is heading
        shifted = data_q >> next_idx;
        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shifted[0];
            PARITY:  tx_next = parity_q;
            default: tx_next = TX_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: table vectors, back-to-back, mid-frame
// reset and randomized frames compared against a bit-schedule reference model.
module tb_uart_tx_frame;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pm = 2'b00;
    logic       s2 = 1'b0;
    logic [7:0] d8 = '0;
    logic [4:0] d5 = '0;
    logic [8:0] d9 = '0;
    logic       v8 = 1'b0, v5 = 1'b0, v9 = 1'b0;
    logic       r8, t8, b8, n8;
    logic       r5, t5, b5, n5;
    logic       r9, t9, b9, n9;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(C)) u8 (
        .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_valid(v8), .tx_ready(r8),
        .parity_mode(pm), .stop2(s2), .tx(t8), .busy(b8), .done(n8));
    uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(C)) u5 (
        .clk(clk), .rst_n(rst_n), .tx_data(d5), .tx_valid(v5), .tx_ready(r5),
        .parity_mode(pm), .stop2(s2), .tx(t5), .busy(b5), .done(n5));
    uart_tx_frame #(.DATA_WIDTH(9), .CLKS_PER_BIT(C)) u9 (
        .clk(clk), .rst_n(rst_n), .tx_data(d9), .tx_valid(v9), .tx_ready(r9),
        .parity_mode(pm), .stop2(s2), .tx(t9), .busy(b9), .done(n9));

    typedef struct {
        logic [8:0] data;
        int         width;
        logic [1:0] pmode;
        logic       stop2;
        int         exp_len;
        logic       has_par;
        logic       exp_par;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {ready, tx, busy, done} of the selected instance
    function automatic logic [3:0] outs(input int w);
        case (w)
            5:       return {r5, t5, b5, n5};
            9:       return {r9, t9, b9, n9};
            default: return {r8, t8, b8, n8};
        endcase
    endfunction

    task automatic applyStimulus(input int w, input logic [8:0] d, input logic v);
        case (w)
            5:       begin d5 = d[4:0]; v5 = v; end
            9:       begin d9 = d;      v9 = v; end
            default: begin d8 = d[7:0]; v8 = v; end
        endcase
    endtask

    function automatic bit has_parity(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    function automatic int frame_len(input int dw, input logic [1:0] m, input logic st2);
        return C * (1 + dw + (has_parity(m) ? 1 : 0) + (st2 ? 2 : 1));
    endfunction

    // Expected line level k cycles after the accept edge (k = 0 is the first)
    function automatic logic model_tx(input logic [8:0] d, input int dw, input logic [1:0] m, input int k);
        int   b = k / C;
        int   ones = 0;
        logic pbit;
        for (int i = 0; i < dw; i++) ones += int'(d[i]);
        pbit = (ones % 2 == 1);
        if (m == 2'b10) pbit = !pbit;
        if (b == 0) return 1'b0;
        if (b <= dw) return d[b-1];
        if (has_parity(m) && b == dw + 1) return pbit;
        return 1'b1;
    endfunction

    // Checks every cycle of a frame whose accept edge has just happened
    task automatic runBody(input int w, input logic [8:0] d, input logic [1:0] m, input logic st2,
                           input logic keep_valid, input logic [8:0] next_d, input string name,
                           output int meas_len, output logic par_seen);
        int         len = frame_len(w, m, st2);
        logic [3:0] o;
        meas_len = -1;
        par_seen = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            o = outs(w);
            checkOutput({name, " tx"}, {31'd0, o[2]}, {31'd0, model_tx(d, w, m, k)});
            checkOutput({name, " done"}, {31'd0, o[0]}, {31'd0, k == len - 1});
            checkOutput({name, " busy"}, {31'd0, o[1]}, 32'd1);
            if (o[0] && meas_len < 0) meas_len = k + 1;
            if (k == C * (1 + w) + 1) par_seen = o[2];
            if (k == 0) begin
                applyStimulus(w, next_d, keep_valid);
                if (!keep_valid) begin
                    pm = 2'($urandom);
                    s2 = 1'($urandom);
                end
            end
        end
    endtask

    task automatic sendFrame(input int w, input logic [8:0] d, input logic [1:0] m, input logic st2,
                             input string name, output int meas_len, output logic par_seen);
        logic [3:0] o;
        int         t = 0;
        meas_len = -1;
        par_seen = 1'b0;
        o = outs(w);
        while (!o[3] && t < 200) begin
            @(negedge clk);
            o = outs(w);
            t++;
        end
        if (!o[3]) begin
            checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
            return;
        end
        pm = m;
        s2 = st2;
        applyStimulus(w, d, 1'b1);
        @(posedge clk);
        runBody(w, d, m, st2, 1'b0, 9'($urandom), name, meas_len, par_seen);
        @(negedge clk);
        o = outs(w);
        checkOutput({name, " post ready"}, {31'd0, o[3]}, 32'd1);
        checkOutput({name, " post busy"}, {31'd0, o[1]}, 32'd0);
        checkOutput({name, " post tx"}, {31'd0, o[2]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         ml;
        logic       ps;
        logic [3:0] o;
        int         seen;
        logic [8:0] rd;
        logic [1:0] rm;
        logic       rs;

        vecs[0] = '{9'h055, 8, 2'b00, 1'b0, 40, 1'b0, 1'b0};
        vecs[1] = '{9'h007, 8, 2'b01, 1'b0, 44, 1'b1, 1'b1};
        vecs[2] = '{9'h007, 8, 2'b10, 1'b0, 44, 1'b1, 1'b0};
        vecs[3] = '{9'h007, 8, 2'b11, 1'b0, 40, 1'b0, 1'b0};
        vecs[4] = '{9'h0A3, 8, 2'b00, 1'b1, 44, 1'b0, 1'b0};
        vecs[5] = '{9'h015, 5, 2'b10, 1'b0, 32, 1'b1, 1'b0};
        vecs[6] = '{9'h1AB, 9, 2'b10, 1'b0, 48, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset tx", {31'd0, t8}, 32'd1);
        checkOutput("reset ready", {31'd0, r8}, 32'd1);
        checkOutput("reset busy", {31'd0, b8}, 32'd0);
        checkOutput("reset done", {31'd0, n8}, 32'd0);
        checkOutput("reset tx w5", {31'd0, t5}, 32'd1);
        checkOutput("reset tx w9", {31'd0, t9}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            sendFrame(vecs[i].width, vecs[i].data, vecs[i].pmode, vecs[i].stop2, $sformatf("vec%0d", i), ml, ps);
            checkOutput($sformatf("vec%0d length", i), ml, vecs[i].exp_len);
            if (vecs[i].has_par)
                checkOutput($sformatf("vec%0d parity", i), {31'd0, ps}, {31'd0, vecs[i].exp_par});
        end

        // Back-to-back with tx_valid held high; data changes during frame 1
        pm = 2'b00;
        s2 = 1'b0;
        applyStimulus(8, 9'h001, 1'b1);
        @(posedge clk);
        runBody(8, 9'h001, 2'b00, 1'b0, 1'b1, 9'h080, "b2b1", ml, ps);
        checkOutput("b2b1 length", ml, 40);
        @(negedge clk);
        checkOutput("b2b gap tx", {31'd0, t8}, 32'd1);
        checkOutput("b2b gap ready", {31'd0, r8}, 32'd1);
        checkOutput("b2b gap busy", {31'd0, b8}, 32'd0);
        @(posedge clk);
        runBody(8, 9'h080, 2'b00, 1'b0, 1'b0, 9'h0FF, "b2b2", ml, ps);
        checkOutput("b2b2 length", ml, 40);
        @(negedge clk);
        checkOutput("b2b2 post ready", {31'd0, r8}, 32'd1);

        // Reset during DATA bit 3 aborts the frame without a done pulse
        pm = 2'b00;
        s2 = 1'b0;
        applyStimulus(8, 9'h0A5, 1'b1);
        @(posedge clk);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            checkOutput("abort pre tx", {31'd0, t8}, {31'd0, model_tx(9'h0A5, 8, 2'b00, k)});
            if (k == 0) applyStimulus(8, 9'h000, 1'b0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort tx", {31'd0, t8}, 32'd1);
        checkOutput("abort busy", {31'd0, b8}, 32'd0);
        checkOutput("abort ready", {31'd0, r8}, 32'd1);
        checkOutput("abort done", {31'd0, n8}, 32'd0);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            o = outs(8);
            if (o[0]) seen++;
        end
        checkOutput("abort no done", seen, 0);
        sendFrame(8, 9'h03C, 2'b01, 1'b0, "after abort", ml, ps);
        checkOutput("after abort length", ml, 44);

        // Randomized frames on the 8-bit instance
        for (int i = 0; i < 20; i++) begin
            rd = {1'b0, 8'($urandom)};
            rm = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            sendFrame(8, rd, rm, rs, $sformatf("rand%0d", i), ml, ps);
            checkOutput($sformatf("rand%0d length", i), ml, frame_len(8, rm, rs));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmit serializer: accepts one data word on a valid/ready handshake and shifts out a complete frame on a single line.
- Frame is start, DATA_WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from an internal clock divider.
- Replaces the fixed start/data/parity/stop select mux with a self-sequencing frame engine; sits between the host-side TX buffer and the pad.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per bit period; minimum 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- tx_data  in  DATA_WIDTH  word to transmit; sampled on accept.
- tx_valid  in  1  host presents tx_data.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none); sampled on accept.
- stop2  in  1  0 = one stop bit, 1 = two stop bits; sampled on accept.
- tx  out  1  serial line, registered, idles high.
- busy  out  1  frame in progress (state not IDLE).
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, tx=1, tx_ready=1, busy=0, done=0, bit timer=0, bit index=0.
- Accept occurs when tx_valid && tx_ready at an edge.
  - On accept, latch tx_data, parity_mode and stop2 into shadow registers.
  - Compute parity from the latched data: even = XOR of data bits; odd = inverted XOR.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if mode none/reserved) -> STOP -> IDLE.
- Each non-IDLE state lasts exactly CLKS_PER_BIT cycles per bit.
  - Bit timer counts 0..CLKS_PER_BIT-1.
  - Bit advance occurs when timer = CLKS_PER_BIT-1.
- Latency: tx goes low on the first cycle after the accept edge.
- DATA: bit index 0..DATA_WIDTH-1; tx = latched_data[index], LSB first.
- PARITY: tx = computed parity bit for one bit period.
- STOP: tx=1 for 1 or 2 bit periods, per the latched stop2.
- done=1 during the final cycle of the last stop bit; next cycle state=IDLE, tx_ready=1, busy=0.
- Frame duration in cycles: CLKS_PER_BIT*(1+DATA_WIDTH+P+S), where P is 0/1 and S is 1/2.
- Back-to-back frames: if tx_valid is held high, accept happens in the single IDLE cycle. This gives exactly one clk cycle of idle-high between consecutive frames.
- tx_valid, tx_data, parity_mode and stop2 are ignored while busy. Changing them mid-frame has no effect on the frame in flight.
- Reset mid-frame: at the next edge with rst_n=0, the frame is aborted and tx=1. No done pulse is produced.
- tx_ready is combinational from state==IDLE; tx, busy and done are registered.
- Counter widths: bit timer $clog2(CLKS_PER_BIT); bit index $clog2(DATA_WIDTH+1).
- Arithmetic is unsigned; no wrap beyond the terminal counts.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10, PAR_RSVD=2'b11;
  - FSM state enum {IDLE, START, DATA, PARITY, STOP};
  - TX_IDLE_LEVEL=1'b1.
- One sub-module, uart_bit_timer (parameter CLKS_PER_BIT):
  - inputs clk, rst_n, run (held low in IDLE);
  - output bit_end, asserted when the count hits CLKS_PER_BIT-1, then wraps to 0.

Test Plan:
- Plain frame, CLKS_PER_BIT=4, DATA_WIDTH=8: tx_data=8'h55, parity none, stop2=0 -> tx bits 0,1,0,1,0,1,0,1,0,1, each 4 cycles; done on cycle 40 after accept; tx_ready high on cycle 41.
- Parity, same parameters: 8'h07 with even parity -> parity bit 1; 8'h07 with odd parity -> parity bit 0. Frame is 44 cycles; parity mode 11 -> no parity bit, 40 cycles.
- Two stop bits: 8'hA3, stop2=1, parity none -> tx high for 8 cycles after the data MSB; done in the last of those cycles.
- Busy-ignore and back-to-back:
  - hold tx_valid high with 8'h01 then 8'h80 -> second frame starts exactly 1 idle-high cycle after the first done;
  - tx_data changes during frame 1 do not corrupt it.
- Reset mid-frame: assert rst_n=0 for one cycle during DATA bit 3 -> tx=1, busy=0, tx_ready=1 after the edge; no done pulse. A subsequent frame is transmitted correctly.
- DATA_WIDTH=5 and DATA_WIDTH=9 builds: 5'h15 and 9'h1AB with odd parity -> correct bit count and parity; frame lengths 32 and 48 cycles at CLKS_PER_BIT=4.
